// File: rtl/pe_outcha_dual_arbiter.sv
// Purpose : round-robin share of one single-pixel output channel between NUM_REQ
//           dual-pixel PE groups; each granted pair is serialized as two beats
//           (one beat for the odd last pair of a frame).
// Latency : grant cycle -> o_valid the next cycle; back-to-back grants give 1 pixel/cycle.
// Backpressure: valid/ready downstream. o_valid, o_data and o_sel hold until i_ready.
//               A new grant is issued only in IDLE or on the final-beat handshake.
// Optional: define PE_OUTCHA_DUAL_ARB_STALL_CNT_EN to build the saturating stall counter
//           on o_stall_cnt; without it o_stall_cnt is tied to zero.
module pe_outcha_dual_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int IN_WIDTH   = 513,
    parameter int IN_HEIGHT  = 257,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int DILATION_0 = 2,
    parameter int DILATION_1 = 2,
    parameter int PADDING_0  = 2,
    parameter int PADDING_1  = 2,
    parameter int STRIDE_0   = 1,
    parameter int STRIDE_1   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_b,
    input  logic [NUM_REQ-1:0]            i_valid,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_sel,
    input  logic                          i_ready,
    output logic                          o_frame_done,
    output logic [31:0]                   o_stall_cnt
);

    // Output frame geometry of the convolution layer feeding this arbiter.
    localparam int OUT_H      = (IN_HEIGHT + 2*PADDING_0 - DILATION_0*(KERNEL_0-1) - 1) / STRIDE_0 + 1;
    localparam int OUT_W      = (IN_WIDTH  + 2*PADDING_1 - DILATION_1*(KERNEL_1-1) - 1) / STRIDE_1 + 1;
    localparam int OUT_PIXELS = OUT_H * OUT_W;
    localparam int PAIRS      = (OUT_PIXELS + 1) / 2;
    localparam bit OUT_ODD    = (OUT_PIXELS % 2) == 1;
    localparam int CNT_W      = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int SEL_W      = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BEAT_A = 2'd1,
        S_BEAT_B = 2'd2
    } state_t;

    state_t                r_state;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [SEL_W-1:0]      r_sel;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_lat_b;
    logic                  r_lat_odd;
    logic                  r_valid;
    logic [CNT_W-1:0]      r_pair_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]    r_done;
    logic                  r_frame_done;

    logic [NUM_REQ-1:0]    w_last_pair;
    logic [NUM_REQ-1:0]    w_last_odd;
    logic                  w_any;
    logic [SEL_W-1:0]      w_gnt_idx;
    logic [DATA_WIDTH-1:0] w_gnt_a;
    logic [DATA_WIDTH-1:0] w_gnt_b;
    logic                  w_gnt_odd;
    logic                  w_final_hs;
    logic                  w_opp;
    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_done_nxt;

    // Per-requester frame position: is the pending pair the last of the frame, and is it a lone pixel.
    always_comb begin
        w_last_pair = '0;
        w_last_odd  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            w_last_pair[r] = (r_pair_cnt[r] == CNT_W'(PAIRS - 1));
            w_last_odd[r]  = OUT_ODD && w_last_pair[r];
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && i_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Select the winner's pair and its odd-last flag.
    always_comb begin
        w_gnt_a   = '0;
        w_gnt_b   = '0;
        w_gnt_odd = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_gnt_idx == SEL_W'(r)) begin
                w_gnt_a   = i_data_a[r*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_b   = i_data_b[r*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_odd = w_last_odd[r];
            end
        end
    end

    // A new pair may be taken when idle or when the last beat of the current pair is accepted.
    assign w_final_hs = r_valid && i_ready &&
                        ((r_state == S_BEAT_B) || ((r_state == S_BEAT_A) && r_lat_odd));
    assign w_opp      = (r_state == S_IDLE) || w_final_hs;
    assign w_grant    = w_opp && w_any && !rst;

    // One-hot acknowledge to the winning requester, in the grant cycle.
    always_comb begin
        o_ack = '0;
        if (w_grant) begin
            o_ack[w_gnt_idx] = 1'b1;
        end
    end

    // Beat sequencer: latch the granted pair, then present beat A (or the lone pixel) and beat B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_sel     <= '0;
            r_lat_b   <= '0;
            r_lat_odd <= 1'b0;
            r_rr_ptr  <= SEL_W'(NUM_REQ - 1);
        end else begin
            if ((r_state == S_BEAT_A) && i_ready && !r_lat_odd) begin
                r_state <= S_BEAT_B;
                r_data  <= r_lat_b;
            end
            if (w_opp) begin
                if (w_any) begin
                    r_state   <= S_BEAT_A;
                    r_valid   <= 1'b1;
                    r_sel     <= w_gnt_idx;
                    r_rr_ptr  <= w_gnt_idx;
                    r_lat_b   <= w_gnt_b;
                    r_lat_odd <= w_gnt_odd;
                    r_data    <= w_gnt_odd ? w_gnt_b : w_gnt_a;
                end else begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    // Pair position within the frame, advanced on each acknowledge and wrapped at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                r_pair_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (o_ack[r]) begin
                    r_pair_cnt[r] <= w_last_pair[r] ? '0 : r_pair_cnt[r] + 1'b1;
                end
            end
        end
    end

    assign w_done_nxt = r_done | (o_ack & w_last_pair);

    // Frame completion: pulse once every requester has sent its last pair, then start over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done       <= '0;
            r_frame_done <= 1'b0;
        end else if (&w_done_nxt) begin
            r_done       <= '0;
            r_frame_done <= 1'b1;
        end else begin
            r_done       <= w_done_nxt;
            r_frame_done <= 1'b0;
        end
    end

`ifdef PE_OUTCHA_DUAL_ARB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where a beat is offered but not accepted; saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 32'd0;
`endif

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_sel        = r_sel;
    assign o_frame_done = r_frame_done;

endmodule
